// File: rtl/cfi_transition_monitor_if.sv
// Bus bundle between the fetch stage and the control-flow transition monitor.
// The master side drives addresses and table writes; the slave side is the monitor.
interface cfi_transition_monitor_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned IDX_W  = 3,
  parameter int unsigned DBG_W  = 16
);
  logic [ADDR_W-1:0] i_instr_addr;
  logic              i_valid;
  logic              i_mode;
  logic              i_clr;
  logic              i_tbl_we;
  logic [IDX_W-1:0]  i_tbl_idx;
  logic [ADDR_W-1:0] i_tbl_src;
  logic [ADDR_W-1:0] i_tbl_dst;
  logic              i_tbl_en;
  logic              o_signal;
  logic              o_match;
  logic [IDX_W-1:0]  o_match_idx;
  logic              o_chk;
  logic              o_alarm;
  logic [15:0]       o_viol_cnt;
  logic [DBG_W-1:0]  debug;

  modport master (
    output i_instr_addr, i_valid, i_mode, i_clr, i_tbl_we, i_tbl_idx, i_tbl_src, i_tbl_dst,
           i_tbl_en,
    input  o_signal, o_match, o_match_idx, o_chk, o_alarm, o_viol_cnt, debug
  );

  modport slave (
    input  i_instr_addr, i_valid, i_mode, i_clr, i_tbl_we, i_tbl_idx, i_tbl_src, i_tbl_dst,
           i_tbl_en,
    output o_signal, o_match, o_match_idx, o_chk, o_alarm, o_viol_cnt, debug
  );
endinterface

// File: rtl/cfi_transition_monitor.sv
// Detects non-sequential fetch-address transitions and checks each (src, dst) pair against a
// programmable table; flags misses (allowlist mode) or hits (watch mode).
module cfi_transition_monitor #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned STEP   = 4,
  parameter int unsigned DBG_W  = 16,
  parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
  input logic                     i_clk,
  input logic                     i_rst,
  cfi_transition_monitor_if.slave bus
);
  logic [ADDR_W-1:0] prev_q, prev_d;
  logic              prev_valid_q, prev_valid_d;
  logic              cap_valid_q, cap_valid_d;
  logic [ADDR_W-1:0] cap_src_q, cap_src_d, cap_dst_q, cap_dst_d;
  logic [DBG_W-1:0]  dbg_q, dbg_d;
  logic [ADDR_W-1:0] tbl_src_q [DEPTH];
  logic [ADDR_W-1:0] tbl_dst_q [DEPTH];
  logic [DEPTH-1:0]  tbl_en_q;
  logic              chk_q, chk_d, sig_q, sig_d, match_q, match_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              alarm_q, alarm_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              cnt_pend_q, cnt_pend_d;
  logic              disc, hit;
  logic [IDX_W-1:0]  hit_idx;

  assign disc = bus.i_valid & prev_valid_q & (bus.i_instr_addr != prev_q) &
                (bus.i_instr_addr != prev_q + ADDR_W'(STEP));

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (tbl_en_q[i] && (tbl_src_q[i] == cap_src_q) && (tbl_dst_q[i] == cap_dst_q)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    prev_d       = bus.i_valid ? bus.i_instr_addr : prev_q;
    prev_valid_d = prev_valid_q | bus.i_valid;
    cap_valid_d  = disc;
    cap_src_d    = disc ? prev_q : cap_src_q;
    cap_dst_d    = disc ? bus.i_instr_addr : cap_dst_q;
    dbg_d        = disc ? prev_q[DBG_W-1:0] : dbg_q;
    chk_d        = cap_valid_q;
    match_d      = cap_valid_q & hit;
    idx_d        = (cap_valid_q & hit) ? hit_idx : '0;
    sig_d        = cap_valid_q & (bus.i_mode ? hit : ~hit);
    // A clear in the same cycle as a fresh pulse suppresses both its alarm and its count.
    alarm_d      = bus.i_clr ? 1'b0 : (alarm_q | sig_d);
    cnt_pend_d   = sig_d & ~bus.i_clr;
    if (bus.i_clr) begin
      cnt_d = '0;
    end else if (cnt_pend_q && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      cap_valid_q  <= 1'b0;
      cap_src_q    <= '0;
      cap_dst_q    <= '0;
      dbg_q        <= '0;
      tbl_en_q     <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        tbl_src_q[i] <= '0;
        tbl_dst_q[i] <= '0;
      end
      chk_q      <= 1'b0;
      sig_q      <= 1'b0;
      match_q    <= 1'b0;
      idx_q      <= '0;
      alarm_q    <= 1'b0;
      cnt_q      <= '0;
      cnt_pend_q <= 1'b0;
    end else begin
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      cap_valid_q  <= cap_valid_d;
      cap_src_q    <= cap_src_d;
      cap_dst_q    <= cap_dst_d;
      dbg_q        <= dbg_d;
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (bus.i_tbl_we && (bus.i_tbl_idx == IDX_W'(i))) begin
          tbl_src_q[i] <= bus.i_tbl_src;
          tbl_dst_q[i] <= bus.i_tbl_dst;
          tbl_en_q[i]  <= bus.i_tbl_en;
        end
      end
      chk_q      <= chk_d;
      sig_q      <= sig_d;
      match_q    <= match_d;
      idx_q      <= idx_d;
      alarm_q    <= alarm_d;
      cnt_q      <= cnt_d;
      cnt_pend_q <= cnt_pend_d;
    end
  end

  assign bus.o_chk       = chk_q;
  assign bus.o_signal    = sig_q;
  assign bus.o_match     = match_q;
  assign bus.o_match_idx = idx_q;
  assign bus.o_alarm     = alarm_q;
  assign bus.o_viol_cnt  = cnt_q;
  assign bus.debug       = dbg_q;
endmodule

// File: tb/tb_cfi_transition_monitor.sv
// Randomised and directed bench for cfi_transition_monitor against a transaction-level model.
module tb_cfi_transition_monitor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  cfi_transition_monitor_if #(.ADDR_W(32), .IDX_W(3), .DBG_W(16)) bus ();

  cfi_transition_monitor #(.ADDR_W(32), .DEPTH(8), .STEP(4), .DBG_W(16)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: what the checker must report, derived from the transition rules.
  logic [31:0] m_prev = 0;
  bit          m_pv = 0;
  bit          m_pair_v = 0;
  logic [31:0] m_pair_src = 0, m_pair_dst = 0;
  logic [31:0] m_src [8];
  logic [31:0] m_dst [8];
  bit          m_en [8];
  bit          m_uncounted = 0;
  bit          e_chk = 0, e_sig = 0, e_match = 0, e_alarm = 0;
  int          e_idx = 0, e_cnt = 0;
  logic [15:0] e_dbg = 0;

  task automatic model_edge();
    bit found;
    int idx;
    bit s;
    if (rst) begin
      m_pv = 0; m_pair_v = 0; m_uncounted = 0;
      m_prev = 0; m_pair_src = 0; m_pair_dst = 0;
      for (int i = 0; i < 8; i++) begin m_src[i] = 0; m_dst[i] = 0; m_en[i] = 0; end
      e_chk = 0; e_sig = 0; e_match = 0; e_idx = 0; e_alarm = 0; e_cnt = 0; e_dbg = 0;
    end else begin
      found = 0; idx = 0;
      for (int i = 0; i < 8; i++)
        if (!found && m_en[i] && m_src[i] == m_pair_src && m_dst[i] == m_pair_dst) begin
          found = 1; idx = i;
        end
      s = m_pair_v && (bus.i_mode ? found : !found);
      if (bus.i_clr) e_cnt = 0;
      else if (m_uncounted && e_cnt < 65535) e_cnt++;
      m_uncounted = s && !bus.i_clr;
      e_alarm = bus.i_clr ? 1'b0 : (e_alarm | s);
      e_chk = m_pair_v; e_sig = s; e_match = m_pair_v && found; e_idx = found ? idx : 0;
      if (bus.i_tbl_we) begin
        m_src[bus.i_tbl_idx] = bus.i_tbl_src;
        m_dst[bus.i_tbl_idx] = bus.i_tbl_dst;
        m_en[bus.i_tbl_idx]  = bus.i_tbl_en;
      end
      m_pair_v = bus.i_valid && m_pv && bus.i_instr_addr != m_prev &&
                 bus.i_instr_addr != m_prev + 32'd4;
      if (m_pair_v) begin
        m_pair_src = m_prev; m_pair_dst = bus.i_instr_addr; e_dbg = m_prev[15:0];
      end
      if (bus.i_valid) begin m_prev = bus.i_instr_addr; m_pv = 1; end
    end
  endtask

  always @(posedge clk) begin
    model_edge();
    #1;
    check("chk", 32'(bus.o_chk), 32'(e_chk));
    check("signal", 32'(bus.o_signal), 32'(e_sig));
    check("alarm", 32'(bus.o_alarm), 32'(e_alarm));
    check("viol_cnt", 32'(bus.o_viol_cnt), 32'(e_cnt));
    check("debug", 32'(bus.debug), 32'(e_dbg));
    if (e_chk) begin
      check("match", 32'(bus.o_match), 32'(e_match));
      check("match_idx", 32'(bus.o_match_idx), 32'(e_idx));
    end
  end

  // Returns just after the edge that sampled the driven values.
  task automatic drive(input bit v, input logic [31:0] a);
    @(negedge clk);
    bus.i_valid = v;
    bus.i_instr_addr = a;
    @(posedge clk);
    #2;
    bus.i_tbl_we = 0;
    bus.i_clr = 0;
    rst = 0;
  endtask

  task automatic wr(input int idx, input logic [31:0] s, input logic [31:0] d, input bit en);
    bus.i_tbl_we = 1; bus.i_tbl_idx = 3'(idx);
    bus.i_tbl_src = s; bus.i_tbl_dst = d; bus.i_tbl_en = en;
    drive(0, 0);
  endtask

  logic [31:0] pool [4];
  logic [31:0] last;

  initial begin
    pool[0] = 32'h100; pool[1] = 32'h200; pool[2] = 32'h500; pool[3] = 32'h9000;
    bus.i_valid = 0; bus.i_instr_addr = 0; bus.i_mode = 0; bus.i_clr = 0;
    bus.i_tbl_we = 0; bus.i_tbl_idx = 0; bus.i_tbl_src = 0; bus.i_tbl_dst = 0; bus.i_tbl_en = 0;
    rst = 1;
    drive(0, 0);
    check("reset_alarm", 32'(bus.o_alarm), 0);
    check("reset_cnt", 32'(bus.o_viol_cnt), 0);
    check("reset_signal", 32'(bus.o_signal), 0);

    wr(0, 32'h0500, 32'h0250, 1);
    wr(1, 32'h9000, 32'h0700, 1);
    wr(2, 32'h9000, 32'h4000, 1);
    wr(3, 32'h0000, 32'h0600, 1);

    // Allowlist hit
    drive(1, 32'h0500); drive(1, 32'h0250); drive(0, 0);
    check("hit_chk", 32'(bus.o_chk), 1);
    check("hit_match", 32'(bus.o_match), 1);
    check("hit_idx", 32'(bus.o_match_idx), 0);
    check("hit_signal", 32'(bus.o_signal), 0);
    drive(0, 0);
    check("hit_cnt", 32'(bus.o_viol_cnt), 0);

    // Allowlist misses
    drive(1, 32'h0200); drive(1, 32'h0100); drive(0, 0);
    check("miss1_signal", 32'(bus.o_signal), 1);
    check("miss1_match", 32'(bus.o_match), 0);
    drive(1, 32'h9000); drive(1, 32'h0000); drive(0, 0);
    check("miss2_signal", 32'(bus.o_signal), 1);
    check("miss_alarm", 32'(bus.o_alarm), 1);
    check("miss_debug", 32'(bus.debug), 32'h9000);
    drive(0, 0);
    check("miss2_one_cycle", 32'(bus.o_signal), 0);

    // Sequential, stall, wrap
    drive(1, 32'h033C); drive(1, 32'h0340); drive(1, 32'h0340);
    check("seq_nochk", 32'(bus.o_chk), 0);
    drive(0, 0);
    check("stall_nochk", 32'(bus.o_chk), 0);
    drive(1, 32'hFFFF_FFFC); drive(1, 32'h0); drive(0, 0);
    check("wrap_nochk", 32'(bus.o_chk), 0);
    drive(1, 32'h033C); drive(1, 32'h0348); drive(0, 0);
    check("skip_chk", 32'(bus.o_chk), 1);

    // Watch mode, priority, write during check
    bus.i_mode = 1;
    wr(1, 32'h9000, 32'h0700, 0);
    wr(2, 32'h9000, 32'h0700, 1);
    wr(3, 32'h9000, 32'h0700, 1);
    drive(1, 32'h9000); drive(1, 32'h0700);
    bus.i_tbl_we = 1; bus.i_tbl_idx = 2; bus.i_tbl_src = 1; bus.i_tbl_dst = 2; bus.i_tbl_en = 1;
    drive(0, 0);
    check("watch_signal", 32'(bus.o_signal), 1);
    check("watch_idx", 32'(bus.o_match_idx), 2);
    drive(1, 32'h9000); drive(1, 32'h0700); drive(0, 0);
    check("watch_after_write_idx", 32'(bus.o_match_idx), 3);

    // Reset mid-stream
    bus.i_mode = 0;
    drive(1, 32'h0100); drive(1, 32'h0800);
    rst = 1;
    drive(0, 0);
    check("rst_signal", 32'(bus.o_signal), 0);
    check("rst_chk", 32'(bus.o_chk), 0);
    check("rst_alarm", 32'(bus.o_alarm), 0);
    check("rst_cnt", 32'(bus.o_viol_cnt), 0);
    check("rst_debug", 32'(bus.debug), 0);
    drive(1, 32'h0500); drive(1, 32'h0250); drive(0, 0);
    check("post_rst_miss", 32'(bus.o_signal), 1);

    // Saturation then clear coinciding with a new pulse
    for (int i = 0; i < 65540; i++) drive(1, (i % 2 == 0) ? 32'h0100 : 32'h0200);
    drive(0, 0); drive(0, 0);
    check("sat_cnt", 32'(bus.o_viol_cnt), 32'hFFFF);
    drive(1, 32'h4000);
    bus.i_clr = 1;
    drive(0, 0);
    check("clr_signal", 32'(bus.o_signal), 1);
    check("clr_alarm", 32'(bus.o_alarm), 0);
    check("clr_cnt", 32'(bus.o_viol_cnt), 0);
    drive(0, 0);
    check("clr_cnt_after", 32'(bus.o_viol_cnt), 0);

    // Randomised traffic
    last = 32'h4000;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 9) == 0) bus.i_mode = ~bus.i_mode;
      bus.i_clr = ($urandom_range(0, 31) == 0);
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 9) == 0) begin
        bus.i_tbl_we = 1; bus.i_tbl_idx = 3'($urandom_range(0, 7));
        bus.i_tbl_src = pool[$urandom_range(0, 3)]; bus.i_tbl_dst = pool[$urandom_range(0, 3)];
        bus.i_tbl_en = ($urandom_range(0, 4) != 0);
      end
      if ($urandom_range(0, 3) == 0) begin
        drive(0, 32'($urandom));
      end else begin
        last = ($urandom_range(0, 1) == 0) ? last + 32'd4 : pool[$urandom_range(0, 3)];
        drive(1, last);
      end
    end
    drive(0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
